// File: rtl/cog_frame_ctrl.sv
// cog_frame_ctrl: frame-level sequencer in front of the CoG pipeline.
// Gates the upstream AXI4-Stream into the core. It checks frame geometry against
// tuser/tlast and waits for the transmitter to drain each frame. Width/height
// changes take effect only between frames.
//
// Ports:
//   i_sys_clk, i_sys_reset         clock, synchronous active-high reset
//   i_enable                       allow new frames to start
//   i_cfg_width/height/valid       config request; o_cfg_ready = slot free
//   o_width, o_height              active geometry driven to the core
//   s_axis_tvalid/tuser/tlast      monitored upstream stream
//   o_up_tready, o_core_tvalid     combinational handshake gating
//   i_core_tready, i_core_eof      core ready, transmitter end-of-frame pulse
//   i_err_clr                      clear sticky errors
//   o_state, o_frame_cnt, o_err    status (registered)
module cog_frame_ctrl #(
    parameter int unsigned DEFAULT_WIDTH  = 1280,
    parameter int unsigned DEFAULT_HEIGHT = 1024,
    parameter int unsigned DRAIN_TIMEOUT  = 4096
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_reset,
    input  logic        i_enable,
    input  logic [10:0] i_cfg_width,
    input  logic [10:0] i_cfg_height,
    input  logic        i_cfg_valid,
    output logic        o_cfg_ready,
    output logic [10:0] o_width,
    output logic [10:0] o_height,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic        o_up_tready,
    output logic        o_core_tvalid,
    input  logic        i_core_tready,
    input  logic        i_core_eof,
    input  logic        i_err_clr,
    output logic [1:0]  o_state,
    output logic [15:0] o_frame_cnt,
    output logic [3:0]  o_err
);

    localparam int unsigned TW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitSof = 2'd1,
        StRun     = 2'd2,
        StDrain   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [10:0]   x_q, x_d, y_q, y_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [10:0]   width_q, width_d, height_q, height_d;
    logic [10:0]   cfg_w_q, cfg_w_d, cfg_h_q, cfg_h_d;
    logic          cfg_free_q, cfg_free_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [3:0]    err_q, err_d, err_set;
    logic          up_tready, core_tvalid;
    logic [10:0]   w_last, h_last;
    logic          apply_cfg;

    assign w_last = width_q - 11'd1;
    assign h_last = height_q - 11'd1;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        timer_d     = timer_q;
        width_d     = width_q;
        height_d    = height_q;
        cfg_w_d     = cfg_w_q;
        cfg_h_d     = cfg_h_q;
        cfg_free_d  = cfg_free_q;
        frame_cnt_d = frame_cnt_q;
        err_set     = 4'b0000;
        up_tready   = 1'b0;
        core_tvalid = 1'b0;
        apply_cfg   = 1'b0;

        unique case (state_q)
            StIdle: begin
                apply_cfg = 1'b1;
                if (i_enable) begin
                    state_d = StWaitSof;
                end
            end
            StWaitSof: begin
                // Non-SOF beats are swallowed here; only the SOF beat reaches the core.
                up_tready   = s_axis_tuser ? i_core_tready : 1'b1;
                core_tvalid = s_axis_tvalid & s_axis_tuser;
                if (s_axis_tvalid && up_tready && s_axis_tuser) begin
                    state_d = StRun;
                    x_d     = 11'd1;
                    y_d     = 11'd0;
                    if (s_axis_tlast && (width_q > 11'd1)) begin
                        err_set[0] = 1'b1;
                        x_d        = 11'd0;
                        y_d        = 11'd1;
                        if (height_q == 11'd1) begin
                            state_d = StDrain;
                            y_d     = 11'd0;
                        end
                    end
                end
            end
            StRun: begin
                core_tvalid = s_axis_tvalid;
                up_tready   = i_core_tready;
                if (s_axis_tvalid && i_core_tready) begin
                    if (s_axis_tuser) begin
                        // Unexpected SOF: resync to the new frame.
                        err_set[2] = 1'b1;
                        x_d        = 11'd1;
                        y_d        = 11'd0;
                    end else if (s_axis_tlast || (x_q == w_last)) begin
                        // Line ends on whichever comes first: tlast or the width count.
                        err_set[0] = (x_q != w_last);
                        err_set[1] = ~s_axis_tlast;
                        x_d        = 11'd0;
                        if (y_q == h_last) begin
                            y_d     = 11'd0;
                            state_d = StDrain;
                        end else begin
                            y_d = y_q + 11'd1;
                        end
                    end else begin
                        x_d = x_q + 11'd1;
                    end
                end
            end
            StDrain: begin
                timer_d = timer_q + 1'b1;
                if (i_core_eof || (timer_q == TW'(DRAIN_TIMEOUT - 1))) begin
                    err_set[3]  = ~i_core_eof;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    apply_cfg   = 1'b1;
                    timer_d     = '0;
                    state_d     = i_enable ? StWaitSof : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Apply and accept are exclusive: apply needs a pending slot, accept a free one.
        if (apply_cfg && !cfg_free_q) begin
            width_d    = cfg_w_q;
            height_d   = cfg_h_q;
            cfg_free_d = 1'b1;
        end
        if (i_cfg_valid && cfg_free_q) begin
            if ((i_cfg_width < 11'd2) || (i_cfg_height == 11'd0)) begin
                err_set[3] = 1'b1;
            end else begin
                cfg_w_d    = i_cfg_width;
                cfg_h_d    = i_cfg_height;
                cfg_free_d = 1'b0;
            end
        end

        // A set in the same cycle as a clear wins.
        err_d = (i_err_clr ? 4'b0000 : err_q) | err_set;

        if (i_sys_reset) begin
            up_tready   = 1'b0;
            core_tvalid = 1'b0;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            timer_q     <= '0;
            width_q     <= 11'(DEFAULT_WIDTH);
            height_q    <= 11'(DEFAULT_HEIGHT);
            cfg_w_q     <= '0;
            cfg_h_q     <= '0;
            cfg_free_q  <= 1'b1;
            frame_cnt_q <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            timer_q     <= timer_d;
            width_q     <= width_d;
            height_q    <= height_d;
            cfg_w_q     <= cfg_w_d;
            cfg_h_q     <= cfg_h_d;
            cfg_free_q  <= cfg_free_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    assign o_up_tready   = up_tready;
    assign o_core_tvalid = core_tvalid;
    assign o_cfg_ready   = cfg_free_q;
    assign o_width       = width_q;
    assign o_height      = height_q;
    assign o_state       = state_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_cog_frame_ctrl.sv
module tb_cog_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [10:0] cfg_width, cfg_height;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [10:0] width, height;
    logic        tvalid, tuser, tlast;
    logic        up_tready, core_tvalid;
    logic        core_tready, core_eof, err_clr;
    logic [1:0]  state;
    logic [15:0] frame_cnt;
    logic [3:0]  err;

    int n_total = 0;
    int n_bad   = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    cog_frame_ctrl #(
        .DEFAULT_WIDTH (1280),
        .DEFAULT_HEIGHT(1024),
        .DRAIN_TIMEOUT (16)
    ) dut (
        .i_sys_clk    (clk),
        .i_sys_reset  (rst),
        .i_enable     (enable),
        .i_cfg_width  (cfg_width),
        .i_cfg_height (cfg_height),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready),
        .o_width      (width),
        .o_height     (height),
        .s_axis_tvalid(tvalid),
        .s_axis_tuser (tuser),
        .s_axis_tlast (tlast),
        .o_up_tready  (up_tready),
        .o_core_tvalid(core_tvalid),
        .i_core_tready(core_tready),
        .i_core_eof   (core_eof),
        .i_err_clr    (err_clr),
        .o_state      (state),
        .o_frame_cnt  (frame_cnt),
        .o_err        (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one beat; the expected forwarding flag is queued and compared on accept.
    task automatic send_beat(input logic user, input logic last, input logic exp_fwd);
        logic accepted;
        int   guard;
        exp_q.push_back(exp_fwd);
        tvalid   = 1'b1;
        tuser    = user;
        tlast    = last;
        accepted = 1'b0;
        guard    = 0;
        while (!accepted && guard < 50) begin
            @(negedge clk);
            if (up_tready) begin
                accepted = 1'b1;
                check("fwd", 32'(core_tvalid), 32'(exp_q.pop_front()));
            end
            @(posedge clk);
            #1;
            guard++;
        end
        if (!accepted) begin
            void'(exp_q.pop_front());
            check("accept_timeout", 32'(accepted), 32'd1);
        end
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) begin
            send_beat(1'b0, (i == n - 1), 1'b1);
        end
    endtask

    task automatic send_cfg(input logic [10:0] w, input logic [10:0] h);
        cfg_valid  = 1'b1;
        cfg_width  = w;
        cfg_height = h;
        tick();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cfg_width = '0; cfg_height = '0; cfg_valid = 1'b0;
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
        core_tready = 1'b1; core_eof = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_width", 32'(width), 32'd1280);
        check("rst_height", 32'(height), 32'd1024);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        tick();
        check("idle_hold", 32'(state), 32'd0);

        // Config 4x3 in IDLE, then one clean frame.
        send_cfg(11'd4, 11'd3);
        check("cfg_busy", 32'(cfg_ready), 32'd0);
        tick();
        check("cfg_w_idle", 32'(width), 32'd4);
        check("cfg_h_idle", 32'(height), 32'd3);
        check("cfg_free", 32'(cfg_ready), 32'd1);
        enable = 1'b1;
        tick();
        check("wait_sof", 32'(state), 32'd1);
        send_beat(1'b1, 1'b0, 1'b1);
        check("run", 32'(state), 32'd2);
        for (int i = 1; i < 12; i++) begin
            send_beat(1'b0, (i % 4 == 3), 1'b1);
        end
        check("drain", 32'(state), 32'd3);
        for (int i = 0; i < 4; i++) tick();
        check("drain_hold", 32'(state), 32'd3);
        core_eof = 1'b1;
        tick();
        core_eof = 1'b0;
        check("f1_cnt", 32'(frame_cnt), 32'd1);
        check("f1_state", 32'(state), 32'd1);
        check("f1_err", 32'(err), 32'd0);

        // eof outside DRAIN is ignored; non-SOF beats are discarded.
        core_eof = 1'b1;
        tick();
        core_eof = 1'b0;
        check("eof_ignored", 32'(frame_cnt), 32'd1);
        for (int i = 0; i < 3; i++) send_beat(1'b0, 1'b0, 1'b0);
        check("discard_state", 32'(state), 32'd1);

        // SOF stalled by the core.
        core_tready = 1'b0;
        tvalid = 1'b1; tuser = 1'b1; tlast = 1'b0;
        @(negedge clk);
        check("stall_tready", 32'(up_tready), 32'd0);
        check("stall_tvalid", 32'(core_tvalid), 32'd1);
        tick();
        check("stall_state", 32'(state), 32'd1);
        core_tready = 1'b1;
        send_beat(1'b1, 1'b0, 1'b1);
        check("sof_run", 32'(state), 32'd2);

        // Early tlast, then missing tlast.
        send_beat(1'b0, 1'b0, 1'b1);
        send_beat(1'b0, 1'b1, 1'b1);
        check("early_tlast", 32'(err), 32'd1);
        send_beat(1'b0, 1'b0, 1'b1);
        send_beat(1'b0, 1'b0, 1'b1);
        send_beat(1'b0, 1'b0, 1'b1);
        send_beat(1'b0, 1'b0, 1'b1);
        check("missing_tlast", 32'(err), 32'd3);
        check("still_run", 32'(state), 32'd2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", 32'(err), 32'd0);

        // Mid-frame SOF resyncs to a new frame.
        send_beat(1'b1, 1'b0, 1'b1);
        check("sof_mid", 32'(err), 32'd4);

        // Config during RUN is held until DRAIN exit.
        send_cfg(11'd8, 11'd2);
        check("run_cfg_busy", 32'(cfg_ready), 32'd0);
        check("run_cfg_w", 32'(width), 32'd4);
        send_line(3);
        send_line(4);
        check("run_cfg_w2", 32'(width), 32'd4);
        send_line(4);
        check("drain2", 32'(state), 32'd3);

        // No eof: timeout after 16 cycles in DRAIN.
        for (int i = 0; i < 15; i++) tick();
        check("to_hold", 32'(state), 32'd3);
        check("to_w_old", 32'(width), 32'd4);
        tick();
        check("to_state", 32'(state), 32'd1);
        check("to_err", 32'(err), 32'hC);
        check("to_cnt", 32'(frame_cnt), 32'd2);
        check("to_w_new", 32'(width), 32'd8);
        check("to_h_new", 32'(height), 32'd2);
        check("to_cfg_free", 32'(cfg_ready), 32'd1);

        // Invalid config.
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        send_cfg(11'd1, 11'd5);
        check("bad_cfg_err", 32'(err), 32'h8);
        check("bad_cfg_free", 32'(cfg_ready), 32'd1);
        tick();
        check("bad_cfg_w", 32'(width), 32'd8);

        // Reset mid-frame at y=1 with a pending config.
        send_beat(1'b1, 1'b0, 1'b1);
        send_line(7);
        send_beat(1'b0, 1'b0, 1'b1);
        send_cfg(11'd16, 11'd4);
        check("pre_rst_busy", 32'(cfg_ready), 32'd0);
        tvalid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_tready", 32'(up_tready), 32'd0);
        check("rst_tvalid", 32'(core_tvalid), 32'd0);
        tick();
        check("mrst_state", 32'(state), 32'd0);
        check("mrst_width", 32'(width), 32'd1280);
        check("mrst_cnt", 32'(frame_cnt), 32'd0);
        check("mrst_err", 32'(err), 32'd0);
        rst = 1'b0; enable = 1'b0; tvalid = 1'b0;
        tick();
        check("cfg_lost", 32'(width), 32'd1280);
        check("cfg_lost_rdy", 32'(cfg_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cog_frame_ctrl.md
Name: cog_frame_ctrl

Overview:
Frame-level sequencer placed in front of the CoG pipeline (receiver, processing, transmitter). It gates the upstream AXI4-Stream into the core and applies WIDTH/HEIGHT reconfiguration only between frames. It checks frame geometry against tuser/tlast and holds the core off until the previous frame has drained out of the transmitter. It also reports frame count, state and sticky error flags.

Parameters:
DEFAULT_WIDTH, 1280, o_width value after reset
DEFAULT_HEIGHT, 1024, o_height value after reset
DRAIN_TIMEOUT, 4096, maximum cycles spent in DRAIN waiting for i_core_eof

Ports:
i_sys_clk  in  1  system clock
i_sys_reset  in  1  synchronous, active-high reset
i_enable  in  1  allow new frames to start
i_cfg_width  in  11  requested line length in pixels
i_cfg_height  in  11  requested frame height in lines
i_cfg_valid  in  1  config request
o_cfg_ready  out  1  config slot free
o_width  out  11  active WIDTH driven to core
o_height  out  11  active HEIGHT driven to core
s_axis_tvalid  in  1  upstream valid (monitored)
s_axis_tuser  in  1  upstream start of frame
s_axis_tlast  in  1  upstream end of line
o_up_tready  out  1  tready returned to upstream
o_core_tvalid  out  1  gated tvalid into core (tdata/tuser/tlast go straight through)
i_core_tready  in  1  core s_axis_tready
i_core_eof  in  1  one-cycle pulse: transmitter finished frame
i_err_clr  in  1  clears all sticky errors
o_state  out  2  0 IDLE, 1 WAIT_SOF, 2 RUN, 3 DRAIN
o_frame_cnt  out  16  completed frames, wraps at 65535->0
o_err  out  4  sticky: [0] early tlast, [1] missing tlast, [2] sof mid-frame, [3] drain timeout or bad cfg

Behaviour:
- Reset: state IDLE, o_width=DEFAULT_WIDTH, o_height=DEFAULT_HEIGHT, no config pending, o_cfg_ready=1, o_frame_cnt=0, o_err=0, x/y counters 0, drain timer 0. o_up_tready=0 and o_core_tvalid=0 while reset is asserted.
- o_up_tready and o_core_tvalid are combinational from the current state and inputs. All other outputs are registered.
- Upstream accept: acc = s_axis_tvalid & o_up_tready.
- IDLE: o_up_tready=0, o_core_tvalid=0. If i_enable=1, move to WAIT_SOF on the next cycle.
- WAIT_SOF: beats with tuser=0 are discarded (o_up_tready=1, o_core_tvalid=0). A beat with tuser=1 is forwarded: o_core_tvalid=1, o_up_tready=i_core_tready. When that beat is accepted, go to RUN with x=1, y=0. If the SOF beat also has tlast=1 and o_width>1, set err[0], x=0, y=1.
- RUN: o_core_tvalid=s_axis_tvalid, o_up_tready=i_core_tready. On each accept, x increments.
  - tlast with x!=o_width-1: set err[0]; x=0, y++.
  - x==o_width-1 without tlast: set err[1]; x=0, y++. The pixel is still forwarded.
  - tuser=1 on any beat after the first: set err[2]; resync x=1, y=0.
  - Accept of the last pixel of line o_height-1: go to DRAIN, x=0, y=0.
  - i_enable=0 mid-frame has no effect; the frame completes.
- DRAIN: o_up_tready=0, o_core_tvalid=0, timer increments each cycle.
  - Exit on i_core_eof, or when timer==DRAIN_TIMEOUT-1 (set err[3]).
  - On exit: o_frame_cnt++; apply any pending config to o_width/o_height; clear pending; go to WAIT_SOF if i_enable else IDLE; timer=0.
  - i_core_eof in any other state is ignored.
- Config handshake: accepted when i_cfg_valid & o_cfg_ready, then o_cfg_ready=0 the next cycle.
  - Invalid config (width<2 or height==0): set err[3], discard, slot stays free.
  - In IDLE, a pending config is applied the cycle after acceptance.
  - In other states it is applied only at DRAIN exit. A second request waits (o_cfg_ready=0).
- i_err_clr clears o_err. A set condition in the same cycle wins, so that bit stays set.
- Reset mid-frame: immediate return to the reset values above. A pending config is lost.

Test Plan:
- Reset, cfg 4x3 accepted in IDLE, enable, 12-beat frame with tuser on beat 0 and tlast on beats 3/7/11 -> o_width=4, o_height=3 one cycle after accept; state WAIT_SOF->RUN->DRAIN after beat 11; i_core_eof 5 cycles later -> o_frame_cnt=1, state WAIT_SOF, o_err=0.
- WAIT_SOF with 3 beats tuser=0 then SOF -> 3 beats consumed with o_core_tvalid=0; SOF forwarded; core i_core_tready=0 stalls SOF, and o_up_tready=0 until it rises.
- Width 4: tlast on beat 2 -> err[0] set, y=1. Next line with no tlast on beat 3 -> err[1] set. i_err_clr -> o_err=0.
- Cfg 8x2 sent during RUN -> o_width stays 4 through the frame and becomes 8 exactly at DRAIN exit; o_cfg_ready=0 until then.
- DRAIN with no i_core_eof, DRAIN_TIMEOUT=16 -> exit after 16 cycles, err[3] set, frame_cnt incremented. Cfg width=1 -> err[3] set, o_width unchanged.
- i_sys_reset asserted in RUN at y=1 -> next cycle state IDLE, o_width=1280, counters 0, o_up_tready=0.
